// File: rtl/commit_stage_n_pkg.sv
// Shared constants for the commit stage slice.
//   RST_ENABLE     : active level of rst
//   STOP / NO_STOP : stall vector bit meanings
//   FLUSH          : active level of flush
//   flush_cause_e  : flush cause encoding (exception = partial kill)
//   ZERO_WORD      : data/PC clear value
//   NOP_REG_ADDR   : destination used for bubbles
package commit_stage_n_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic FLUSH      = 1'b1;

    typedef enum logic {
        CAUSE_OTHER = 1'b0,
        CAUSE_EXC   = 1'b1
    } flush_cause_e;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;

endpackage

// File: rtl/commit_stage_n_lane_popcount.sv
// lane_popcount: combinational population count of a lane mask.
//   mask  in  LANES   lane bit mask
//   count out LW+1    number of set bits
module lane_popcount #(
    parameter int LANES = 2,
    parameter int LW    = 1
) (
    input  logic [LANES-1:0] mask,
    output logic [LW:0]      count
);

    always_comb begin
        count = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            count = count + (LW+1)'(mask[k]);
        end
    end

endmodule

// File: rtl/commit_stage_n.sv
// commit_stage_n: MEM->WB commit register for LANES retiring instructions
// plus one HI/LO write. Supports per-lane valid, precise exception kill,
// full flush, bubble/hold via the stall vector, a retired-instruction
// counter and a last-retired-PC register.
//   clk, rst                 clock, synchronous active-high reset
//   flush, flush_cause       flush request; cause 1 = exception (partial kill)
//   exc_lane_i               excepting lane (lanes >= it are squashed)
//   stall[2]/stall[3]        upstream / downstream stall
//   valid_i/pc_i/waddr_i/we_i/wdata_i   per-lane inputs (lane 0 oldest)
//   whilo_i/hilo_lane_i/hi_i/lo_i       HI/LO write and owning lane
//   *_o                      registered copies, we_o gated by valid
//   last_pc_o                PC of the youngest instruction retired so far
//   retired_cnt_o            instructions retired since reset (wrapping)
module commit_stage_n
    import commit_stage_n_pkg::*;
#(
    parameter  int LANES  = 2,
    parameter  int ADDR_W = 5,
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 64,
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     flush_cause,
    input  logic [LW-1:0]            exc_lane_i,
    input  logic [4:0]               stall,
    input  logic [LANES-1:0]         valid_i,
    input  logic [LANES*DATA_W-1:0]  pc_i,
    input  logic [LANES*ADDR_W-1:0]  waddr_i,
    input  logic [LANES-1:0]         we_i,
    input  logic [LANES*DATA_W-1:0]  wdata_i,
    input  logic                     whilo_i,
    input  logic [LW-1:0]            hilo_lane_i,
    input  logic [DATA_W-1:0]        hi_i,
    input  logic [DATA_W-1:0]        lo_i,
    output logic [LANES-1:0]         valid_o,
    output logic [LANES*DATA_W-1:0]  pc_o,
    output logic [LANES*ADDR_W-1:0]  waddr_o,
    output logic [LANES-1:0]         we_o,
    output logic [LANES*DATA_W-1:0]  wdata_o,
    output logic                     whilo_o,
    output logic [DATA_W-1:0]        hi_o,
    output logic [DATA_W-1:0]        lo_o,
    output logic [DATA_W-1:0]        last_pc_o,
    output logic [CNT_W-1:0]         retired_cnt_o
);

    logic                    load_en;
    logic [LANES-1:0]        keep;
    logic                    hilo_keep;
    logic                    hilo_ok;
    logic [LANES-1:0]        valid_n;
    logic [LANES-1:0]        we_n;
    logic [LANES*DATA_W-1:0] pc_n;
    logic [LANES*ADDR_W-1:0] waddr_n;
    logic [LANES*DATA_W-1:0] wdata_n;
    logic                    whilo_n;
    logic [DATA_W-1:0]       hi_n;
    logic [DATA_W-1:0]       lo_n;
    logic [LANES-1:0]        ret_mask;
    logic [DATA_W-1:0]       last_pc_n;
    logic [LW:0]             pop_cnt;
    logic [2:0]              unused_stall;

    assign unused_stall = {stall[4], stall[1:0]};

    always_comb begin
        load_en   = 1'b1;
        keep      = '1;
        hilo_keep = 1'b1;
        hilo_ok   = 1'b0;
        // hilo_lane_i may name a lane that does not exist when LANES is not a power of two
        for (int unsigned k = 0; k < LANES; k++) begin
            if (32'(hilo_lane_i) == k) hilo_ok = valid_i[k];
        end
        whilo_n = whilo_i && hilo_ok;

        if (flush == FLUSH) begin
            if (flush_cause == CAUSE_EXC) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    keep[k] = (k < 32'(exc_lane_i));
                end
                whilo_n = whilo_n && (hilo_lane_i < exc_lane_i);
            end else begin
                keep      = '0;
                hilo_keep = 1'b0;
                whilo_n   = 1'b0;
            end
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            keep      = '0;
            hilo_keep = 1'b0;
            whilo_n   = 1'b0;
        end else if (stall[2] == STOP) begin
            load_en = 1'b0;
        end

        for (int unsigned k = 0; k < LANES; k++) begin
            valid_n[k] = keep[k] && valid_i[k];
            we_n[k]    = valid_n[k] && we_i[k];
            pc_n[k*DATA_W +: DATA_W]    = keep[k] ? pc_i[k*DATA_W +: DATA_W]    : DATA_W'(ZERO_WORD);
            wdata_n[k*DATA_W +: DATA_W] = keep[k] ? wdata_i[k*DATA_W +: DATA_W] : DATA_W'(ZERO_WORD);
            waddr_n[k*ADDR_W +: ADDR_W] = keep[k] ? waddr_i[k*ADDR_W +: ADDR_W] : ADDR_W'(NOP_REG_ADDR);
        end
        hi_n = hilo_keep ? hi_i : DATA_W'(ZERO_WORD);
        lo_n = hilo_keep ? lo_i : DATA_W'(ZERO_WORD);

        ret_mask = load_en ? valid_n : '0;

        // Ascending scan: the highest-indexed retiring lane is written last
        last_pc_n = last_pc_o;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (ret_mask[k]) last_pc_n = pc_i[k*DATA_W +: DATA_W];
        end
    end

    lane_popcount #(
        .LANES (LANES),
        .LW    (LW)
    ) u_popcount (
        .mask  (ret_mask),
        .count (pop_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_o       <= '0;
            pc_o          <= '0;
            waddr_o       <= '0;
            we_o          <= '0;
            wdata_o       <= '0;
            whilo_o       <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
            last_pc_o     <= '0;
            retired_cnt_o <= '0;
        end else if (load_en) begin
            valid_o       <= valid_n;
            pc_o          <= pc_n;
            waddr_o       <= waddr_n;
            we_o          <= we_n;
            wdata_o       <= wdata_n;
            whilo_o       <= whilo_n;
            hi_o          <= hi_n;
            lo_o          <= lo_n;
            last_pc_o     <= last_pc_n;
            retired_cnt_o <= retired_cnt_o + CNT_W'(pop_cnt);
        end
    end

endmodule

// File: tb/tb_commit_stage_n.sv
module tb_commit_stage_n;

    localparam int LANES  = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int LW     = 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic                    flush_cause;
    logic [LW-1:0]           exc_lane_i;
    logic [4:0]              stall;
    logic [LANES-1:0]        valid_i;
    logic [LANES*DATA_W-1:0] pc_i;
    logic [LANES*ADDR_W-1:0] waddr_i;
    logic [LANES-1:0]        we_i;
    logic [LANES*DATA_W-1:0] wdata_i;
    logic                    whilo_i;
    logic [LW-1:0]           hilo_lane_i;
    logic [DATA_W-1:0]       hi_i;
    logic [DATA_W-1:0]       lo_i;
    logic [LANES-1:0]        valid_o;
    logic [LANES*DATA_W-1:0] pc_o;
    logic [LANES*ADDR_W-1:0] waddr_o;
    logic [LANES-1:0]        we_o;
    logic [LANES*DATA_W-1:0] wdata_o;
    logic                    whilo_o;
    logic [DATA_W-1:0]       hi_o;
    logic [DATA_W-1:0]       lo_o;
    logic [DATA_W-1:0]       last_pc_o;
    logic [CNT_W-1:0]        retired_cnt_o;

    commit_stage_n #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .flush_cause   (flush_cause),
        .exc_lane_i    (exc_lane_i),
        .stall         (stall),
        .valid_i       (valid_i),
        .pc_i          (pc_i),
        .waddr_i       (waddr_i),
        .we_i          (we_i),
        .wdata_i       (wdata_i),
        .whilo_i       (whilo_i),
        .hilo_lane_i   (hilo_lane_i),
        .hi_i          (hi_i),
        .lo_i          (lo_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .waddr_o       (waddr_o),
        .we_o          (we_o),
        .wdata_o       (wdata_o),
        .whilo_o       (whilo_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .last_pc_o     (last_pc_o),
        .retired_cnt_o (retired_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  valid;
        logic [63:0] pc;
        logic [9:0]  waddr;
        logic [1:0]  we;
        logic [63:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] last_pc;
        logic [3:0]  cnt;
    } exp_t;

    exp_t m;
    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour, written case by case from the stage description.
    task automatic model_step();
        exp_t n;
        logic [1:0] lane_ld;
        logic       hl_ld;
        logic       wh;
        logic       ld;
        n = m;
        if (rst) begin
            n = '0;
        end else begin
            ld = 1'b1;
            lane_ld = 2'b11;
            hl_ld = 1'b1;
            wh = whilo_i && valid_i[hilo_lane_i];
            if (flush && flush_cause) begin
                lane_ld = (exc_lane_i == 1'b0) ? 2'b00 : 2'b01;
                wh = wh && (hilo_lane_i < exc_lane_i);
            end else if (flush) begin
                lane_ld = 2'b00; hl_ld = 1'b0; wh = 1'b0;
            end else if (stall[2] && !stall[3]) begin
                lane_ld = 2'b00; hl_ld = 1'b0; wh = 1'b0;
            end else if (stall[2]) begin
                ld = 1'b0;
            end
            if (ld) begin
                for (int l = 0; l < 2; l++) begin
                    n.valid[l] = lane_ld[l] & valid_i[l];
                    n.we[l]    = lane_ld[l] & valid_i[l] & we_i[l];
                    n.pc[l*32 +: 32]    = lane_ld[l] ? pc_i[l*32 +: 32] : 32'h0;
                    n.wdata[l*32 +: 32] = lane_ld[l] ? wdata_i[l*32 +: 32] : 32'h0;
                    n.waddr[l*5 +: 5]   = lane_ld[l] ? waddr_i[l*5 +: 5] : 5'h0;
                end
                n.whilo = wh;
                n.hi = hl_ld ? hi_i : 32'h0;
                n.lo = hl_ld ? lo_i : 32'h0;
                n.cnt = m.cnt + 4'(n.valid[0]) + 4'(n.valid[1]);
                if (n.valid[1])      n.last_pc = pc_i[63:32];
                else if (n.valid[0]) n.last_pc = pc_i[31:0];
            end
        end
        m = n;
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        check("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("valid_o",   64'(valid_o),       64'(e.valid));
            check("we_o",      64'(we_o),          64'(e.we));
            check("pc_o",      pc_o,               e.pc);
            check("waddr_o",   64'(waddr_o),       64'(e.waddr));
            check("wdata_o",   wdata_o,            e.wdata);
            check("whilo_o",   64'(whilo_o),       64'(e.whilo));
            check("hi_o",      64'(hi_o),          64'(e.hi));
            check("lo_o",      64'(lo_o),          64'(e.lo));
            check("last_pc_o", 64'(last_pc_o),     64'(e.last_pc));
            check("cnt_o",     64'(retired_cnt_o), 64'(e.cnt));
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1);
        valid_i = v;
        we_i    = we;
        pc_i    = {pc1, pc0};
        waddr_i = {wa1, wa0};
        wdata_i = {wd1, wd0};
    endtask

    task automatic ctrl(input logic r, input logic f, input logic fc,
                        input logic el, input logic [4:0] st);
        rst = r; flush = f; flush_cause = fc; exc_lane_i = el; stall = st;
    endtask

    initial begin
        m = '0;
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
        drive(2'b11, 2'b11, 32'h55, 32'h66, 5'd1, 5'd2, 32'h1, 32'h2);
        whilo_i = 1'b1; hilo_lane_i = 1'b0; hi_i = 32'hDEAD; lo_i = 32'hBEEF;
        cycle();
        check("reset_cnt", 64'(retired_cnt_o), 64'd0);
        check("reset_valid", 64'(valid_o), 64'd0);

        // Reset then pass
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        whilo_i = 1'b0;
        drive(2'b11, 2'b11, 32'h100, 32'h104, 5'd3, 5'd7, 32'hA, 32'hB);
        cycle();
        check("pass_we", 64'(we_o), 64'h3);
        check("pass_waddr", 64'(waddr_o), 64'({5'd7, 5'd3}));
        check("pass_cnt", 64'(retired_cnt_o), 64'd2);
        check("pass_last_pc", 64'(last_pc_o), 64'h104);

        // Bubble then hold on the bubble
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'b00100);
        drive(2'b11, 2'b11, 32'h150, 32'h154, 5'd4, 5'd5, 32'hC, 32'hD);
        cycle();
        check("bubble_valid", 64'(valid_o), 64'd0);
        check("bubble_cnt", 64'(retired_cnt_o), 64'd2);
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'b01100);
        cycle();

        // Load then hold for three cycles with changing inputs
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        drive(2'b11, 2'b01, 32'h200, 32'h204, 5'd8, 5'd9, 32'h20, 32'h21);
        cycle();
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'b01100);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b11, 32'h300 + 32'(i), 32'h400 + 32'(i), 5'd10, 5'd11, 32'h30, 32'h31);
            cycle();
        end
        check("hold_pc", pc_o, {32'h204, 32'h200});
        check("hold_cnt", 64'(retired_cnt_o), 64'd4);

        // Exception in lane 1, HI/LO owned by lane 1
        ctrl(1'b0, 1'b1, 1'b1, 1'b1, 5'b00000);
        drive(2'b11, 2'b11, 32'h500, 32'h504, 5'd12, 5'd13, 32'h50, 32'h51);
        whilo_i = 1'b1; hilo_lane_i = 1'b1; hi_i = 32'h1111; lo_i = 32'h2222;
        cycle();
        check("exc_valid", 64'(valid_o), 64'h1);
        check("exc_whilo", 64'(whilo_o), 64'd0);
        check("exc_cnt", 64'(retired_cnt_o), 64'd5);
        check("exc_last_pc", 64'(last_pc_o), 64'h500);

        // Exception in lane 1, HI/LO owned by the older lane survives
        hilo_lane_i = 1'b0;
        cycle();
        check("exc_whilo_old", 64'(whilo_o), 64'd1);

        // Exception in lane 0 kills everything
        ctrl(1'b0, 1'b1, 1'b1, 1'b0, 5'b00000);
        cycle();
        // Flush during hold wins
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 5'b01100);
        cycle();
        // Full flush overrides pass, then reset in the same cycle wins
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        cycle();
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 5'b00000);
        cycle();
        check("flush_valid", 64'(valid_o), 64'd0);
        ctrl(1'b1, 1'b1, 1'b0, 1'b0, 5'b00000);
        cycle();
        check("flush_rst_cnt", 64'(retired_cnt_o), 64'd0);

        // Hole in valid and shared destination
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        whilo_i = 1'b0;
        drive(2'b10, 2'b11, 32'h600, 32'h604, 5'd6, 5'd6, 32'h60, 32'h61);
        cycle();
        drive(2'b11, 2'b11, 32'h700, 32'h704, 5'd6, 5'd6, 32'h70, 32'h71);
        cycle();
        check("dup_we", 64'(we_o), 64'h3);

        // Counter wrap
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
        cycle();
        ctrl(1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        for (int i = 0; i < 15; i++) begin
            drive(2'b01, 2'b01, 32'h800 + 32'(i*4), 32'h0, 5'd1, 5'd0, 32'(i), 32'h0);
            cycle();
        end
        check("wrap_pre", 64'(retired_cnt_o), 64'd15);
        drive(2'b11, 2'b11, 32'h900, 32'h904, 5'd2, 5'd3, 32'h90, 32'h91);
        cycle();
        check("wrap_cnt", 64'(retired_cnt_o), 64'd1);

        // Random mix
        for (int i = 0; i < 200; i++) begin
            ctrl(($urandom_range(0, 31) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
                 1'($urandom), 5'($urandom));
            drive(2'($urandom), 2'($urandom), $urandom, $urandom,
                  5'($urandom), 5'($urandom), $urandom, $urandom);
            whilo_i = 1'($urandom); hilo_lane_i = 1'($urandom);
            hi_i = $urandom; lo_i = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
